// File: rtl/pwm_capture.sv
// pwm_capture -- receive-side PWM measurement.
//   Measures the high time and period of an incoming PWM line in clk cycles and
//   converts them to an 8-bit duty code on the generator's scale:
//   code = high*256/period, saturated to 255.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   pwm_in      asynchronous PWM input (synchronized internally)
//   duty_cycle  recovered duty code
//   high_time   high cycles of the last complete period
//   period      total cycles of the last complete period
//   duty_valid  one-cycle strobe; all result outputs update in that cycle
//   stuck       1 = last result came from a timeout (static line)
//   overrun     sticky; a measurement was dropped because the divider was busy
//
// Build option: define PWM_CAPTURE_FILTER_EN to insert a 3-sample glitch filter
// after the synchronizer (adds 2 cycles to every latency).

module pwm_capture #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  output logic [7:0]           duty_cycle,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 duty_valid,
  output logic                 stuck,
  output logic                 overrun
);

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [3:0]           DIV_STEPS   = 4'd9;

  // Synchronizer: s1/s2 double-flop, s3 holds the previous line level.
  // All reset high so a line already high at reset release is not a rise.
  logic s1, s2, s3;
  logic lvl;
  logic rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= lvl;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Level follows s2 only once three consecutive samples agree; s3 then
  // holds the previous filtered level.
  logic h1, h2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 <= 1'b1;
      h2 <= 1'b1;
    end else begin
      h1 <= s2;
      h2 <= h1;
    end
  end

  always_comb begin
    lvl = s3;
    if (s2 == h1 && s2 == h2) lvl = s2;
  end
`else
  always_comb lvl = s2;
`endif

  assign rise = lvl & ~s3;

  // Measurement state
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt_hi;
  logic [CNT_WIDTH-1:0] cnt_per;

  // Serial restoring divider: compare-then-shift, MSB quotient bit first.
  // The dividend is cnt_hi*256 and cnt_hi <= cnt_per, so nine quotient bits
  // starting with remainder = cnt_hi cover the whole range.
  logic                 div_busy;
  logic [3:0]           div_cnt;
  logic [CNT_WIDTH:0]   div_rem;
  logic [CNT_WIDTH-1:0] div_per;
  logic [CNT_WIDTH-1:0] div_hi;
  logic [8:0]           div_q;
  logic [CNT_WIDTH-1:0] div_diff;
  logic                 div_ge;
  logic                 div_free;
  logic                 timeout;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    div_ge   = div_rem >= {1'b0, div_per};
    // Only used when div_ge, where the difference is below div_per.
    div_diff = div_rem[CNT_WIDTH-1:0] - div_per;
    // The divider may accept a new capture in the cycle it writes its result,
    // which is what makes a 10-cycle period sustainable.
    div_free = ~div_busy | (div_cnt == 4'd0);
    timeout  = (cnt_per == TIMEOUT_CNT) & ~rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      cnt_hi     <= '0;
      cnt_per    <= '0;
      div_busy   <= 1'b0;
      div_cnt    <= '0;
      div_rem    <= '0;
      div_per    <= '0;
      div_hi     <= '0;
      div_q      <= '0;
      duty_cycle <= '0;
      high_time  <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;

      // Divider: nine iteration cycles, then one cycle to publish the result.
      if (div_busy) begin
        if (div_cnt != 4'd0) begin
          if (div_ge) begin
            div_rem <= {div_diff, 1'b0};
            div_q   <= {div_q[7:0], 1'b1};
          end else begin
            div_rem <= {div_rem[CNT_WIDTH-1:0], 1'b0};
            div_q   <= {div_q[7:0], 1'b0};
          end
          div_cnt <= div_cnt - 4'd1;
        end else begin
          div_busy   <= 1'b0;
          duty_cycle <= div_q[8] ? 8'hFF : div_q[7:0];
          high_time  <= div_hi;
          period     <= div_per;
          stuck      <= 1'b0;
          duty_valid <= 1'b1;
        end
      end

      // Timeout writes the outputs after the divider block, so it overrides
      // (and thereby drops) a divider result completing in the same cycle.
      if (timeout) begin
        duty_cycle <= lvl ? 8'hFF : 8'h00;
        high_time  <= '0;
        period     <= '0;
        stuck      <= 1'b1;
        duty_valid <= 1'b1;
        state      <= SYNC;
        cnt_hi     <= '0;
        cnt_per    <= '0;
      end else begin
        case (state)
          SYNC: begin
            if (rise) begin
              state   <= HIGH;
              cnt_hi  <= CNT_WIDTH'(1);
              cnt_per <= CNT_WIDTH'(1);
            end else begin
              cnt_per <= sat_inc(cnt_per);
            end
          end
          HIGH: begin
            cnt_per <= sat_inc(cnt_per);
            if (lvl) cnt_hi <= sat_inc(cnt_hi);
            else     state  <= LOW;
          end
          LOW: begin
            if (rise) begin
              if (div_free) begin
                div_busy <= 1'b1;
                div_cnt  <= DIV_STEPS;
                div_rem  <= {1'b0, cnt_hi};
                div_per  <= cnt_per;
                div_hi   <= cnt_hi;
                div_q    <= '0;
              end else begin
                overrun  <= 1'b1;
              end
              // The edge cycle is the first high cycle of the next period.
              state   <= HIGH;
              cnt_hi  <= CNT_WIDTH'(1);
              cnt_per <= CNT_WIDTH'(1);
            end else begin
              cnt_per <= sat_inc(cnt_per);
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule
